// File: rtl/newhope_pkg.sv
// Shared NewHope constants and the packer state encoding.
package newhope_pkg;

  localparam int NH_Q         = 12289;  // NewHope modulus
  localparam int NH_N         = 1024;   // default polynomial length
  localparam int COEFF_W      = 14;     // reduced coefficient width
  localparam int GROUP_COEFFS = 4;      // coefficients per packing group
  localparam int GROUP_BYTES  = 7;      // 4 x 14 bits = 56 bits = 7 bytes
  localparam int PACK_W       = COEFF_W * GROUP_COEFFS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } pk_state_e;

endpackage

// File: rtl/poly_tobytes_packer.sv
// Packs 14-bit NewHope coefficients into bytes, 4 coefficients -> 7 bytes,
// LSB first. Accepts a group of four, then streams the 7 bytes out before
// taking the next group. All outputs decode registered state only.
module poly_tobytes_packer
  import newhope_pkg::*;
#(
  parameter int N = NH_N,
  parameter int Q = NH_Q
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COEFF_W-1:0] coeff_in,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               busy,
  output logic               done,
  output logic               range_err
);

  // Counter must hold the value N itself without wrapping.
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [2:0]       LAST_J = 3'(GROUP_BYTES - 1);
  localparam logic [COEFF_W:0] Q_W    = (COEFF_W + 1)'(Q);

  pk_state_e          r_state, w_next;
  logic [1:0]         r_grp;
  logic [2:0]         r_j;
  logic [CNT_W-1:0]   r_cnt;
  logic [PACK_W-1:0]  r_pack;
  logic               r_err;

  logic w_accept, w_take, w_grp_full, w_poly_done;
  logic [7:0] w_byte;

  // Ready is a pure state decode, so qualify the handshake with state here.
  assign w_accept    = coeff_valid && (r_state == ST_COLLECT);
  assign w_take      = byte_ready && (r_state == ST_EMIT);
  assign w_grp_full  = (r_grp == 2'd3);
  assign w_poly_done = (r_cnt == CNT_W'(N));
  assign range_err   = r_err;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state and state-decoded handshake/status outputs.
  always_comb begin
    w_next      = r_state;
    coeff_ready = 1'b0;
    byte_valid  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        coeff_ready = 1'b1;
        busy        = 1'b1;
        if (w_accept && w_grp_full) w_next = ST_EMIT;
      end
      ST_EMIT: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        if (w_take && (r_j == LAST_J))
          w_next = w_poly_done ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Byte select out of the pack register; zero whenever not presenting data.
  always_comb begin
    w_byte = 8'h00;
    for (int j = 0; j < GROUP_BYTES; j++)
      if (r_j == 3'(j)) w_byte = r_pack[8*j +: 8];
  end
  assign byte_out = byte_valid ? w_byte : 8'h00;

  // Counters, pack register and sticky range flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grp  <= '0;
      r_j    <= '0;
      r_cnt  <= '0;
      r_pack <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_grp <= '0;
        r_j   <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end
      if (w_accept) begin
        for (int k = 0; k < GROUP_COEFFS; k++)
          if (r_grp == 2'(k)) r_pack[COEFF_W*k +: COEFF_W] <= coeff_in;
        r_grp <= r_grp + 2'd1;
        r_cnt <= r_cnt + 1'b1;
        // Out-of-range values are flagged but still packed as-is.
        if ({1'b0, coeff_in} >= Q_W) r_err <= 1'b1;
      end
      if (w_take) r_j <= (r_j == LAST_J) ? 3'd0 : r_j + 3'd1;
    end
  end

endmodule
